// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  localparam int SYS_CLOCK            = 1_000_000;
  localparam int BAUD_RATE            = 9600;
  // One stop bit's worth of system clocks.
  localparam int DEFAULT_GUARD_CYCLES = SYS_CLOCK / BAUD_RATE;

  localparam int GRANT_W = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GUARD     = 3'd4
  } state_t;

  // Width able to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request above ptr, with wrap.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GRANT_W-1:0] idx,
  output logic               valid
);

  localparam int unsigned NU = NUM_REQ;

  int unsigned ptr_u;
  assign ptr_u = 32'(ptr);

  // Scan ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ); the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned off = 1; off <= NU; off++) begin
      if (!valid && (((req >> ((ptr_u + off) % NU)) & NUM_REQ'(1)) != '0)) begin
        valid = 1'b1;
        grant = NUM_REQ'(1) << ((ptr_u + off) % NU);
        idx   = GRANT_W'((ptr_u + off) % NU);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte producers, round-robin,
// with a stop-bit guard gap and a busy-handshake timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     done,
  output logic [GRANT_W-1:0]     grant_id,
  output logic                   active,
  output logic                   tx_send,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic                   err_timeout
);

  localparam int GW = cnt_width(GUARD_CYCLES);
  localparam int TW = cnt_width(BUSY_TIMEOUT);

  localparam logic [GW-1:0]      GUARD_LOAD   = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;
  localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GRANT_W-1:0] PTR_RESET    = GRANT_W'(NUM_REQ - 1);

  state_t               state, state_next;
  logic [GRANT_W-1:0]   ptr, ptr_next;
  logic [GW-1:0]        guard_cnt, guard_next;
  logic [TW-1:0]        busy_cnt, busy_next;

  logic [NUM_REQ-1:0]   ack_next, done_next;
  logic [GRANT_W-1:0]   grant_next;
  logic                 active_next, tx_send_next, err_next;
  logic [7:0]           tx_data_next;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [GRANT_W-1:0]   pick_idx;
  logic                 pick_valid;
  logic [7:0]           pick_byte;
  logic [NUM_REQ-1:0]   done_onehot;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign pick_byte   = 8'(req_data >> {pick_idx, 3'b000});
  assign done_onehot = NUM_REQ'(1) << grant_id;

  // State, counters and all outputs are registered; reset restores idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= PTR_RESET;
      guard_cnt   <= '0;
      busy_cnt    <= '0;
      ack         <= '0;
      done        <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      tx_send     <= 1'b0;
      tx_data     <= 8'h00;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      guard_cnt   <= guard_next;
      busy_cnt    <= busy_next;
      ack         <= ack_next;
      done        <= done_next;
      grant_id    <= grant_next;
      active      <= active_next;
      tx_send     <= tx_send_next;
      tx_data     <= tx_data_next;
      err_timeout <= err_next;
    end
  end

  // Next-state and next-output logic; pulses default low, levels hold.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    guard_next   = guard_cnt;
    busy_next    = busy_cnt;
    ack_next     = '0;
    done_next    = '0;
    tx_send_next = 1'b0;
    grant_next   = grant_id;
    active_next  = active;
    tx_data_next = tx_data;
    err_next     = err_timeout;

    case (state)
      IDLE: begin
        // Foreign serializer activity blocks any grant.
        if (pick_valid && !tx_busy) begin
          tx_data_next = pick_byte;
          grant_next   = pick_idx;
          ack_next     = pick_grant;
          active_next  = 1'b1;
          ptr_next     = pick_idx;
          state_next   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_send_next = 1'b1;
        busy_next    = '0;
        state_next   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (busy_cnt == TIMEOUT_LAST) begin
          err_next   = 1'b1;
          done_next  = done_onehot;
          guard_next = GUARD_LOAD;
          state_next = GUARD;
        end else begin
          busy_next = busy_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_next  = done_onehot;
          guard_next = GUARD_LOAD;
          state_next = GUARD;
        end
      end
      GUARD: begin
        if (guard_cnt == '0) begin
          active_next = 1'b0;
          state_next  = IDLE;
        end else begin
          guard_next = guard_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a uart_tx busy model and a
// launch scoreboard; a second instance is built with no guard gap.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int G        = 104;
  localparam int BT       = 8;
  localparam int FRAME    = 1040;
  localparam int G0_FRAME = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic [N-1:0]   req, req_b;
  logic [8*N-1:0] req_data, req_data_b;
  logic [N-1:0]   ack, done, ack_b, done_b;
  logic [2:0]     grant_id, grant_id_b;
  logic           active, tx_send, tx_busy, err_timeout;
  logic           active_b, tx_send_b, tx_busy_b, err_timeout_b;
  logic [7:0]     tx_data, tx_data_b;

  uart_tx_arbiter #(
    .NUM_REQ(N), .GUARD_CYCLES(G), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .grant_id(grant_id), .active(active),
    .tx_send(tx_send), .tx_data(tx_data), .tx_busy(tx_busy),
    .err_timeout(err_timeout)
  );

  uart_tx_arbiter #(
    .NUM_REQ(N), .GUARD_CYCLES(0), .BUSY_TIMEOUT(BT)
  ) dut_g0 (
    .clk(clk), .reset_n(reset_n), .req(req_b), .req_data(req_data_b),
    .ack(ack_b), .done(done_b), .grant_id(grant_id_b), .active(active_b),
    .tx_send(tx_send_b), .tx_data(tx_data_b), .tx_busy(tx_busy_b),
    .err_timeout(err_timeout_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mute;
  int unsigned bcnt, bcnt_b;
  logic [10:0] q[$];
  logic [10:0] qb[$];
  logic spacing_on, spacing_b_on;
  int last_launch, last_b;
  int ack1_b_count = 0;
  int n, dn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer models: busy rises the cycle after send and lasts one frame.
  always @(posedge clk) begin
    if (!reset_n) begin
      tx_busy <= 1'b0; bcnt <= 0;
    end else if (tx_send && !mute) begin
      tx_busy <= 1'b1; bcnt <= FRAME;
    end else if (tx_busy) begin
      if (bcnt == 1) tx_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      tx_busy_b <= 1'b0; bcnt_b <= 0;
    end else if (tx_send_b) begin
      tx_busy_b <= 1'b1; bcnt_b <= G0_FRAME;
    end else if (tx_busy_b) begin
      if (bcnt_b == 1) tx_busy_b <= 1'b0;
      bcnt_b <= bcnt_b - 1;
    end
  end

  // Scoreboard: every launch must match the next expected {grant_id, byte}.
  always @(negedge clk) begin
    if (reset_n && tx_send) begin
      chk("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) chk("sb_launch", {grant_id, tx_data}, q.pop_front());
      if (spacing_on && last_launch >= 0) chk("spacing_min", (cyc - last_launch) >= FRAME + G, 1);
      last_launch <= cyc;
    end
  end

  always @(negedge clk) begin
    if (reset_n && tx_send_b) begin
      chk("g0_sb_nonempty", qb.size() != 0, 1);
      if (qb.size() != 0) chk("g0_sb_launch", {grant_id_b, tx_data_b}, qb.pop_front());
      if (spacing_b_on && last_b >= 0) chk("g0_spacing", cyc - last_b, G0_FRAME + 5);
      last_b <= cyc;
    end
    if (ack_b[1]) ack1_b_count <= ack1_b_count + 1;
  end

  function automatic logic cond(input int sel);
    case (sel)
      0: return tx_send;
      1: return done != '0;
      2: return !active;
      3: return ack != '0;
      4: return tx_send_b;
      5: return !active_b;
      default: return ack_b != '0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, input string tag, output int cnt);
    cnt = 0;
    while (!cond(sel) && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, cond(sel), 1);
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_ack"}, ack, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_tx_send"}, tx_send, 0);
    chk({pfx, "_active"}, active, 0);
    chk({pfx, "_err"}, err_timeout, 0);
    chk({pfx, "_tx_data"}, tx_data, 0);
    chk({pfx, "_grant_id"}, grant_id, 0);
  endtask

  initial begin
    reset_n = 1'b0; req = '0; req_data = '0; req_b = '0; req_data_b = '0;
    mute = 1'b0; spacing_on = 1'b0; spacing_b_on = 1'b0;
    last_launch = -1; last_b = -1;
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    reset_n = 1'b1;

    // Single request
    @(negedge clk);
    req_data[7:0] = 8'hA5; req = 4'b0001; q.push_back({3'd0, 8'hA5});
    @(negedge clk);
    chk("t1_ack", ack, 4'b0001);
    chk("t1_active", active, 1);
    req = '0;
    @(negedge clk);
    chk("t1_tx_send", tx_send, 1);
    chk("t1_ack_clear", ack, 0);
    wait_for(1, 3000, "t1_done_seen", n);
    chk("t1_done", done, 4'b0001);
    chk("t1_busy_low", tx_busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    wait_for(2, 300, "t1_active_low", n);
    chk("t1_guard_len", n + 1, G);

    // Four continuous requesters from a fresh reset
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    q.push_back({3'd0, 8'h10}); q.push_back({3'd1, 8'h11});
    q.push_back({3'd2, 8'h12}); q.push_back({3'd3, 8'h13});
    q.push_back({3'd0, 8'h10});
    spacing_on = 1'b1; last_launch = -1;
    for (int i = 0; i < 5; i++) begin
      wait_for(0, 2000, "t2_launch", n);
      if (i < 4) @(negedge clk);
    end
    req = '0;
    wait_for(2, 2000, "t2_idle", n);
    spacing_on = 1'b0;
    chk("t2_sb_drained", q.size(), 0);

    // Pointer wrap: grant 2, then {0,2} requesting picks 0
    @(negedge clk);
    req_data[23:16] = 8'h22; req = 4'b0100; q.push_back({3'd2, 8'h22});
    wait_for(3, 10, "t3a_ack_seen", n);
    chk("t3a_ack", ack, 4'b0100);
    req = '0;
    wait_for(2, 2000, "t3a_idle", n);
    req_data[7:0] = 8'h30; req_data[23:16] = 8'h32; req = 4'b0101;
    q.push_back({3'd0, 8'h30});
    wait_for(3, 10, "t3b_ack_seen", n);
    chk("t3b_ack", ack, 4'b0001);
    chk("t3b_grant_id", grant_id, 0);
    req = '0;
    wait_for(2, 2000, "t3b_idle", n);

    // Timeout: serializer never raises busy
    mute = 1'b1;
    req_data[15:8] = 8'h44; req = 4'b0010; q.push_back({3'd1, 8'h44});
    wait_for(3, 10, "t4_ack_seen", n);
    req = '0;
    wait_for(0, 10, "t4_launch", n);
    @(negedge clk);
    wait_for(1, 50, "t4_done_seen", n);
    chk("t4_done_delay", n + 1, BT);
    chk("t4_done", done, 4'b0010);
    chk("t4_err", err_timeout, 1);
    mute = 1'b0;
    req_data[7:0] = 8'h55; req = 4'b0001; q.push_back({3'd0, 8'h55});
    wait_for(3, 300, "t4_next_ack_seen", n);
    chk("t4_next_after_gap", n, G + 1);
    chk("t4_err_sticky", err_timeout, 1);
    req = '0;
    wait_for(0, 10, "t4_next_launch", n);
    wait_for(2, 2000, "t4_idle", n);

    // Reset in the middle of a frame
    req_data[7:0] = 8'h66; req = 4'b0001; q.push_back({3'd0, 8'h66});
    wait_for(3, 10, "t5_ack_seen", n);
    req = '0;
    wait_for(0, 10, "t5_launch", n);
    repeat (20) @(negedge clk);
    chk("t5_in_frame", tx_busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_reset_values("t5");
    dn = 0;
    repeat (50) begin
      @(negedge clk);
      if (done != '0) dn++;
    end
    chk("t5_no_done", dn, 0);
    req_data[7:0] = 8'h77; req_data[15:8] = 8'h78; req = 4'b0011;
    q.push_back({3'd0, 8'h77});
    wait_for(3, 10, "t5_ack_seen2", n);
    chk("t5_first_grant", ack, 4'b0001);
    req = '0;
    wait_for(0, 10, "t5_launch2", n);
    wait_for(2, 2000, "t5_idle", n);
    chk("t5_sb_drained", q.size(), 0);

    // No-guard build: withdrawn request, then back-to-back launches
    req_data_b[7:0] = 8'hB0; req_data_b[15:8] = 8'hB1; req_b = 4'b0011;
    qb.push_back({3'd0, 8'hB0});
    wait_for(6, 10, "t6_ack_seen", n);
    chk("t6_ack", ack_b, 4'b0001);
    req_b = '0;
    wait_for(5, 200, "t6_idle", n);
    repeat (5) @(negedge clk);
    chk("t6_no_ack1", ack1_b_count, 0);
    req_data_b[7:0] = 8'hC0; req_data_b[23:16] = 8'hC2; req_b = 4'b0101;
    qb.push_back({3'd2, 8'hC2}); qb.push_back({3'd0, 8'hC0});
    spacing_b_on = 1'b1; last_b = -1;
    wait_for(4, 10, "t6_launch1", n);
    @(negedge clk);
    wait_for(4, 200, "t6_launch2", n);
    req_b = '0;
    wait_for(5, 200, "t6_idle2", n);
    spacing_b_on = 1'b0;
    chk("t6_sb_drained", qb.size(), 0);
    chk("t6_no_ack1_final", ack1_b_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
